// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg -- shared definitions for the instruction encoder.
//   * RV32I major opcodes for the four supported formats
//   * fmt_e: request format selector (matches the in_fmt encoding)
//   * enc_state_e: output-register occupancy state
//   * immediate range limits and a range-check helper
// The range-check helper is only used when INSTR_ENC_RANGE_CHECK_EN is defined.
package riscv_enc_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FMT_LOAD   = 2'd0,
        FMT_OPIMM  = 2'd1,
        FMT_STORE  = 2'd2,
        FMT_BRANCH = 2'd3
    } fmt_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_e;

    // 12-bit signed immediate (I/S) and 13-bit even byte offset (B).
    localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_IS_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;

    // True when imm cannot be represented exactly in the format's field.
    function automatic logic imm_out_of_range(input fmt_e fmt, input logic [31:0] imm);
        logic signed [31:0] s;
        s = signed'(imm);
        if (fmt == FMT_BRANCH) begin
            return (s < IMM_B_MIN) || (s > IMM_B_MAX) || imm[0];
        end
        return (s < IMM_IS_MIN) || (s > IMM_IS_MAX);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack -- purely combinational RV32I field packer.
// Ports:
//   fmt    : request format (load / op-imm / store / branch)
//   rd     : destination register (I formats only)
//   rs1    : source register 1
//   rs2    : source register 2 (S/B formats only)
//   funct3 : funct3 field
//   imm    : low 13 immediate bits; higher bits never reach the encoding
//   instr  : packed 32-bit instruction word
module instr_pack
    import riscv_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [12:0] imm,
    output logic [31:0] instr
);

    always_comb begin
        instr = '0;
        case (fmt)
            FMT_LOAD:   instr = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            FMT_OPIMM:  instr = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
            FMT_STORE:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            // Branch offsets are scrambled; imm[0] is implicitly zero.
            FMT_BRANCH: instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], OPC_BRANCH};
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- registers one encoded RV32I instruction per request and
// tags each emitted word with a sequential byte address.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   defined   : out-of-range immediates are accepted, dropped, and flagged on
//               err (one cycle later) and counted in err_count (saturating).
//   undefined : immediates are silently truncated; err/err_count are 0.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer must hold valid and its payload until that edge; ready
// may depend combinationally on the opposite side (in_ready follows out_ready).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake
//   in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm : request fields
//   out_valid/out_ready : output handshake
//   out_instr, out_addr : encoded word and its byte address
//   err, err_count      : rejection pulse and saturating rejection count
// The output register state is visible as out_valid (1 = FULL).
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    enc_state_e        state_q, state_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       packed_instr;

    logic accept;     // request handshake this cycle
    logic reject;     // accepted but dropped for a bad immediate
    logic load;       // accepted and written into the output register
    logic handshake;  // output word consumed this cycle

    instr_pack u_pack (
        .fmt    (fmt_e'(in_fmt)),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .imm    (in_imm[12:0]),
        .instr  (packed_instr)
    );

    assign accept    = in_valid && in_ready;
    assign load      = accept && !reject;
    assign handshake = out_valid && out_ready;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;

    assign reject = accept && imm_out_of_range(fmt_e'(in_fmt), in_imm);

    always_comb begin
        err_d       = reject;
        err_count_d = err_count_q;
        if (reject && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    // Bits above the widest encoded field only matter to the range check.
    logic imm_hi_unused;
    assign imm_hi_unused = ^in_imm[31:13];

    assign reject    = 1'b0;
    assign err       = 1'b0;
    assign err_count = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A load wins over a handshake, so a simultaneous
    // consume-and-refill keeps the register FULL.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if (handshake) begin
            state_d = ST_EMPTY;
        end
    end

    // FSM: outputs. in_ready is forced low in reset so nothing is taken
    // while the register is being cleared.
    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = !reset && ((state_q == ST_EMPTY) || out_ready);
    end

    // Datapath: the word only changes on a load, so it is stable under
    // backpressure. The address advances once per consumed word.
    always_comb begin
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        if (load) begin
            out_instr_d = packed_instr;
        end
        if (handshake) begin
            out_addr_d = out_addr_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
        end else begin
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder -- directed, table-driven bench for instr_encoder.
// Encodings in the vector table were worked out by hand from the RV32I
// field layouts; addresses are tracked by the bench from BASE_ADDR = 0.
module tb_instr_encoder;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_count;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] exp_instr;
    } vec_t;

    localparam int N_VEC = 11;
    vec_t vecs[N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.funct3;
        in_imm    = v.imm;
    endtask

    // One request with out_ready high: accept, then check the word next cycle.
    task automatic send_vec(input int idx);
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(vecs[idx]);
        check($sformatf("v%0d_idle_out_valid", idx), 32'(out_valid), 32'd0);
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_out_instr", idx), out_instr, vecs[idx].exp_instr);
        check($sformatf("v%0d_out_addr", idx), out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
    endtask

    initial begin
        vec_t bad;

        //          fmt   rd     rs1    rs2    f3    imm           expected
        vecs[0]  = '{2'd0, 5'd5,  5'd2,  5'd0,  3'd2, 32'd8,        32'h00812283};
        vecs[1]  = '{2'd2, 5'd17, 5'd2,  5'd5,  3'd2, 32'hFFFFFFFC, 32'hFE512E23};
        vecs[2]  = '{2'd3, 5'd3,  5'd1,  5'd2,  3'd0, 32'hFFFFFFF8, 32'hFE208CE3};
        vecs[3]  = '{2'd1, 5'd1,  5'd0,  5'd31, 3'd0, 32'd1,        32'h00100093};
        vecs[4]  = '{2'd1, 5'd31, 5'd31, 5'd0,  3'd7, 32'hFFFFFFFF, 32'hFFFFFF93};
        vecs[5]  = '{2'd0, 5'd0,  5'd0,  5'd0,  3'd0, 32'd2047,     32'h7FF00003};
        vecs[6]  = '{2'd1, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFFF800, 32'h80000013};
        vecs[7]  = '{2'd2, 5'd9,  5'd0,  5'd0,  3'd0, 32'd2047,     32'h7E000FA3};
        vecs[8]  = '{2'd3, 5'd0,  5'd0,  5'd0,  3'd0, 32'd4094,     32'h7E000FE3};
        vecs[9]  = '{2'd3, 5'd31, 5'd0,  5'd0,  3'd0, 32'hFFFFF000, 32'h80000063};
        vecs[10] = '{2'd3, 5'd0,  5'd3,  5'd4,  3'd1, 32'd16,       32'h00419863};

        // Reset, with out_ready high to show in_ready is still held low.
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        exp_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;

        // Table: one word at a time, addresses 0, 4, 8, ...
        for (int i = 0; i < N_VEC; i++) begin
            send_vec(i);
        end

        // Backpressure: two back-to-back requests while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(vecs[0]);
        check("bp_first_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(vecs[0].exp_instr);
        @(negedge clk);
        drive_req(vecs[1]);
        exp_q.push_back(vecs[1].exp_instr);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_blocked", 32'(in_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_instr", k), out_instr, exp_q[0]);
            check($sformatf("bp_hold%0d_addr", k), out_addr, exp_addr);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_word0_instr", out_instr, exp_q.pop_front());
        check("bp_word0_addr", out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_word1_valid", 32'(out_valid), 32'd1);
        check("bp_word1_instr", out_instr, exp_q.pop_front());
        check("bp_word1_addr", out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Immediate just past the I range.
        bad = '{2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000013};
`ifdef INSTR_ENC_RANGE_CHECK_EN
        @(negedge clk);
        drive_req(bad);
        check("rng_i_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rng_i_err", 32'(err), 32'd1);
        check("rng_i_no_valid", 32'(out_valid), 32'd0);
        check("rng_i_err_count", 32'(err_count), 32'd1);
        check("rng_i_addr", out_addr, exp_addr);
        @(negedge clk);
        check("rng_i_err_pulse", 32'(err), 32'd0);
        // Odd branch offset.
        bad = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5, 32'h0};
        drive_req(bad);
        check("rng_b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rng_b_err", 32'(err), 32'd1);
        check("rng_b_no_valid", 32'(out_valid), 32'd0);
        check("rng_b_err_count", 32'(err_count), 32'd2);
        // The next good word takes the address the rejected ones did not.
        send_vec(3);
`else
        @(negedge clk);
        drive_req(bad);
        check("trunc_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("trunc_out_valid", 32'(out_valid), 32'd1);
        check("trunc_imm_field", 32'(out_instr[31:20]), 32'h800);
        check("trunc_out_instr", out_instr, bad.exp_instr);
        check("trunc_out_addr", out_addr, exp_addr);
        check("trunc_err", 32'(err), 32'd0);
        check("trunc_err_count", 32'(err_count), 32'd0);
        exp_addr = exp_addr + 32'd4;
`endif

        // Reset while FULL: the pending word must be discarded.
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(vecs[4]);
        @(negedge clk);
        in_valid = 1'b0;
        check("rf_full", 32'(out_valid), 32'd1);
        check("rf_addr_before", out_addr, exp_addr);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rf_in_ready_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_out_addr", out_addr, 32'd0);
        check("rf_out_instr", out_instr, 32'd0);
        check("rf_err", 32'(err), 32'd0);
        check("rf_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rf_stays_empty", 32'(out_valid), 32'd0);
        exp_addr = '0;
        send_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
